// File: rtl/clock_sequencer.sv
// Board-clock sequencer: timed, synchronously released resetn with soft re-arm,
// and a registered clock enable with run / divide / debounced step / pause modes.
module clock_sequencer #(
    parameter int HOLD_CYCLES = 4096,
    parameter int DIV_W       = 24,
    parameter int DEB_CYCLES  = 65536
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [1:0]       mode,
    input  logic [DIV_W-1:0] div,
    input  logic             step_btn,
    input  logic             soft_reset,
    output logic             resetn,
    output logic             ce,
    output logic [31:0]      ce_count
);

    localparam logic [1:0] MODE_RUN   = 2'b00;
    localparam logic [1:0] MODE_DIV   = 2'b01;
    localparam logic [1:0] MODE_STEP  = 2'b10;
    localparam logic [1:0] MODE_PAUSE = 2'b11;

    localparam int               DEB_W     = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [15:0]      HOLD_LAST = 16'(HOLD_CYCLES - 1);
    localparam logic [DEB_W-1:0] DEB_LAST  = DEB_W'(DEB_CYCLES - 1);
    localparam logic [DEB_W-1:0] DEB_ONE   = DEB_W'(1'b1);
    localparam logic [DIV_W-1:0] DIV_ONE   = DIV_W'(1'b1);

    typedef enum logic {
        ST_HOLD = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    logic             rs1_r, rs2_r;
    state_t           state_r, state_s;
    logic [15:0]      hold_cnt_r, hold_cnt_s;
    logic             resetn_r, resetn_s;
    logic             soft_take_s;

    logic             ce_r, ce_s;
    logic [DIV_W-1:0] dcnt_r, dcnt_s;
    logic [1:0]       mode_q_r;
    logic [31:0]      ce_count_r, ce_count_s;

    logic             btn_s1_r, bs_r, deb_r, deb_q_r;
    logic             deb_s;
    logic [DEB_W-1:0] deb_cnt_r, deb_cnt_s;
    logic             rise_s;

    assign soft_take_s = (state_r == ST_RUN) && soft_reset;
    assign rise_s      = deb_r & ~deb_q_r;

    // Reset-release synchroniser. Dropping rs2 on a soft reset makes the re-armed
    // hold take the same HOLD_CYCLES+1 edges as a power-up release.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            rs1_r <= 1'b0;
            rs2_r <= 1'b0;
        end else begin
            rs1_r <= 1'b1;
            rs2_r <= soft_take_s ? 1'b0 : rs1_r;
        end
    end

    // Hold FSM next state: count the hold window, then release resetn
    always_comb begin
        state_s    = state_r;
        hold_cnt_s = hold_cnt_r;
        resetn_s   = resetn_r;
        case (state_r)
            ST_HOLD: begin
                resetn_s = 1'b0;
                if (rs2_r) begin
                    if (hold_cnt_r == HOLD_LAST) begin
                        state_s    = ST_RUN;
                        hold_cnt_s = 16'd0;
                        resetn_s   = 1'b1;
                    end else begin
                        hold_cnt_s = hold_cnt_r + 16'd1;
                    end
                end else begin
                    hold_cnt_s = 16'd0;
                end
            end
            ST_RUN: begin
                if (soft_reset) begin
                    state_s    = ST_HOLD;
                    hold_cnt_s = 16'd0;
                    resetn_s   = 1'b0;
                end else begin
                    resetn_s   = 1'b1;
                end
            end
            default: begin
                state_s    = ST_HOLD;
                hold_cnt_s = 16'd0;
                resetn_s   = 1'b0;
            end
        endcase
    end

    // Hold FSM registers
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_r    <= ST_HOLD;
            hold_cnt_r <= 16'd0;
            resetn_r   <= 1'b0;
        end else begin
            state_r    <= state_s;
            hold_cnt_r <= hold_cnt_s;
            resetn_r   <= resetn_s;
        end
    end

    // Enable generation; the divider uses >= so lowering div never stalls it
    always_comb begin
        ce_s   = 1'b0;
        dcnt_s = {DIV_W{1'b0}};
        if ((state_r == ST_RUN) && !soft_reset) begin
            case (mode)
                MODE_RUN: begin
                    ce_s = 1'b1;
                end
                MODE_DIV: begin
                    if (dcnt_r >= div) begin
                        ce_s   = 1'b1;
                        dcnt_s = {DIV_W{1'b0}};
                    end else begin
                        ce_s   = 1'b0;
                        dcnt_s = dcnt_r + DIV_ONE;
                    end
                    if (mode != mode_q_r) begin
                        dcnt_s = {DIV_W{1'b0}};
                    end else begin
                        dcnt_s = dcnt_s;
                    end
                end
                MODE_STEP: begin
                    ce_s = rise_s;
                end
                MODE_PAUSE: begin
                    ce_s = 1'b0;
                end
                default: begin
                    ce_s = 1'b0;
                end
            endcase
        end else begin
            ce_s   = 1'b0;
            dcnt_s = {DIV_W{1'b0}};
        end

        if (soft_take_s) begin
            ce_count_s = 32'd0;
        end else if (ce_r) begin
            ce_count_s = ce_count_r + 32'd1;
        end else begin
            ce_count_s = ce_count_r;
        end
    end

    // Enable, divider and enable-count registers
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            ce_r       <= 1'b0;
            dcnt_r     <= {DIV_W{1'b0}};
            mode_q_r   <= MODE_RUN;
            ce_count_r <= 32'd0;
        end else begin
            ce_r       <= ce_s;
            dcnt_r     <= dcnt_s;
            mode_q_r   <= mode;
            ce_count_r <= ce_count_s;
        end
    end

    // Debounce: the level follows bs only after DEB_CYCLES consecutive differing samples
    always_comb begin
        deb_s     = deb_r;
        deb_cnt_s = deb_cnt_r;
        if (bs_r != deb_r) begin
            if (deb_cnt_r == DEB_LAST) begin
                deb_s     = bs_r;
                deb_cnt_s = {DEB_W{1'b0}};
            end else begin
                deb_cnt_s = deb_cnt_r + DEB_ONE;
            end
        end else begin
            deb_cnt_s = {DEB_W{1'b0}};
        end
    end

    // Button synchroniser, debounce state and edge-detect history (runs in every mode)
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            btn_s1_r  <= 1'b0;
            bs_r      <= 1'b0;
            deb_r     <= 1'b0;
            deb_q_r   <= 1'b0;
            deb_cnt_r <= {DEB_W{1'b0}};
        end else begin
            btn_s1_r  <= step_btn;
            bs_r      <= btn_s1_r;
            deb_r     <= deb_s;
            deb_q_r   <= deb_r;
            deb_cnt_r <= deb_cnt_s;
        end
    end

    assign resetn   = resetn_r;
    assign ce       = ce_r;
    assign ce_count = ce_count_r;

endmodule

// File: tb/tb_clock_sequencer.sv
// Scoreboard bench for clock_sequencer: a cycle reference model pushes expected
// outputs each edge; a negedge monitor pops and compares them.
module tb_clock_sequencer;

    localparam int HOLD = 8;
    localparam int DEB  = 4;
    localparam int DW   = 8;

    logic          CLK = 1'b0;
    logic          RESET;
    logic [1:0]    mode;
    logic [DW-1:0] div;
    logic          step_btn;
    logic          soft_reset;
    logic          resetn;
    logic          ce;
    logic [31:0]   ce_count;

    clock_sequencer #(.HOLD_CYCLES(HOLD), .DIV_W(DW), .DEB_CYCLES(DEB)) dut (
        .CLK(CLK), .RESET(RESET), .mode(mode), .div(div), .step_btn(step_btn),
        .soft_reset(soft_reset), .resetn(resetn), .ce(ce), .ce_count(ce_count)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic        resetn;
        logic        ce;
        logic [31:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   errors = 0;
    int   checks = 0;

    // Reference model state
    bit          m_running;
    int          m_hold_left;
    logic        m_resetn, m_ce;
    logic [31:0] m_cnt;
    int          m_phase;
    logic [1:0]  m_prev_mode;
    logic        m_b1, m_b2, m_deb, m_debq;
    logic        bs_win[$];

    logic [31:0] cnt0;
    int          rl;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_running   = 1'b0;
        m_hold_left = HOLD + 2;   // resetn rises on the (HOLD+2)th edge after release
        m_resetn    = 1'b0;
        m_ce        = 1'b0;
        m_cnt       = 32'd0;
        m_phase     = 0;
        m_prev_mode = 2'b00;
        m_b1        = 1'b0;
        m_b2        = 1'b0;
        m_deb       = 1'b0;
        m_debq      = 1'b0;
        bs_win.delete();
    endtask

    task automatic model_step();
        logic bs_used, flip, rise, was_running, soft_take;
        exp_t e;
        if (!RESET) begin
            model_reset();
        end else begin
            // button seen two edges late; debounced level flips after DEB differing samples
            bs_used = m_b2;
            m_b2    = m_b1;
            m_b1    = step_btn;
            bs_win.push_back(bs_used);
            if (bs_win.size() > DEB) void'(bs_win.pop_front());
            flip = (bs_win.size() == DEB);
            foreach (bs_win[i]) if (bs_win[i] == m_deb) flip = 1'b0;
            rise   = m_deb & ~m_debq;
            m_debq = m_deb;
            if (flip) m_deb = ~m_deb;

            was_running = m_running;
            soft_take   = m_running && soft_reset;
            if (soft_take) m_cnt = 32'd0;
            else           m_cnt = m_cnt + {31'd0, m_ce};

            if (soft_take || !was_running) begin
                m_ce    = 1'b0;
                m_phase = 0;
            end else begin
                case (mode)
                    2'b00: begin m_ce = 1'b1; m_phase = 0; end
                    2'b01: begin
                        if (m_phase >= int'(div)) begin m_ce = 1'b1; m_phase = 0; end
                        else begin m_ce = 1'b0; m_phase++; end
                        if (mode != m_prev_mode) m_phase = 0;
                    end
                    2'b10: begin m_ce = rise; m_phase = 0; end
                    default: begin m_ce = 1'b0; m_phase = 0; end
                endcase
            end
            m_prev_mode = mode;

            if (soft_take) begin
                m_running   = 1'b0;
                m_resetn    = 1'b0;
                m_hold_left = HOLD + 1;
            end else if (!m_running) begin
                m_hold_left--;
                if (m_hold_left == 0) begin
                    m_running = 1'b1;
                    m_resetn  = 1'b1;
                end
            end
        end
        e.resetn = m_resetn;
        e.ce     = m_ce;
        e.cnt    = m_cnt;
        exp_q.push_back(e);
    endtask

    initial forever begin
        @(posedge CLK);
        model_step();
    end

    // Monitor: one expected entry per edge, compared mid-cycle
    initial forever begin
        @(negedge CLK);
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            if (!RESET) mon_e = '0;
            chk("sb_resetn", {31'd0, resetn}, {31'd0, mon_e.resetn});
            chk("sb_ce", {31'd0, ce}, {31'd0, mon_e.ce});
            chk("sb_ce_count", ce_count, mon_e.cnt);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK);
            #2;
        end
    endtask

    initial begin
        RESET = 1'b0; mode = 2'b00; div = '0; step_btn = 1'b0; soft_reset = 1'b0;
        tick(3);
        chk("rst_resetn", {31'd0, resetn}, 32'd0);
        chk("rst_ce", {31'd0, ce}, 32'd0);
        chk("rst_count", ce_count, 32'd0);

        // Power-up in RUN: resetn rises at E9, ce from E10
        RESET = 1'b1;
        tick(9);
        chk("pwr_resetn_e8", {31'd0, resetn}, 32'd0);
        tick(1);
        chk("pwr_resetn_e9", {31'd0, resetn}, 32'd1);
        chk("pwr_ce_e9", {31'd0, ce}, 32'd0);
        tick(1);
        chk("pwr_ce_e10", {31'd0, ce}, 32'd1);
        tick(10);
        chk("pwr_count10", ce_count, 32'd10);

        // DIV=3, then div->0 while the divider sits at 2
        mode = 2'b01; div = 8'd3;
        tick(24);
        for (int i = 0; i < 8; i++) if (m_phase != 2) tick(1);
        chk("div_sync", 32'(m_phase), 32'd2);
        div = 8'd0;
        tick(1);
        chk("div0_nostall", {31'd0, ce}, 32'd1);
        tick(6);

        // STEP with a 3-cycle bounce then clean presses
        mode = 2'b10;
        tick(5);
        cnt0 = m_cnt;
        step_btn = 1'b1; tick(1);
        step_btn = 1'b0; tick(1);
        step_btn = 1'b1; tick(20);
        step_btn = 1'b0; tick(20);
        chk("step_one", ce_count, cnt0 + 32'd1);
        step_btn = 1'b1; tick(20);
        step_btn = 1'b0; tick(20);
        chk("step_two", ce_count, cnt0 + 32'd2);

        // Soft reset in RUN; a second request during HOLD must not extend it
        mode = 2'b00;
        tick(5);
        soft_reset = 1'b1; tick(1); soft_reset = 1'b0;
        chk("soft_resetn", {31'd0, resetn}, 32'd0);
        chk("soft_count", ce_count, 32'd0);
        tick(3);
        soft_reset = 1'b1; tick(1); soft_reset = 1'b0;
        tick(HOLD - 4);
        chk("soft_hold_e8", {31'd0, resetn}, 32'd0);
        tick(1);
        chk("soft_hold_e9", {31'd0, resetn}, 32'd1);
        tick(4);

        // Press consumed in PAUSE must not fire after switching to STEP
        mode = 2'b11;
        tick(3);
        cnt0 = m_cnt;
        step_btn = 1'b1; tick(15);
        mode = 2'b10; tick(10);
        step_btn = 1'b0; tick(15);
        chk("pause_no_step", ce_count, cnt0);

        // RUN -> DIV(2): first pulse three cycles after the change
        mode = 2'b00; tick(5);
        mode = 2'b01; div = 8'd2;
        tick(3);
        chk("div2_e2", {31'd0, ce}, 32'd0);
        tick(1);
        chk("div2_e3", {31'd0, ce}, 32'd1);

        // Asynchronous RESET in the middle of a DIV pulse
        for (int i = 0; i < 12; i++) if (ce !== 1'b1) tick(1);
        chk("async_pulse_seen", {31'd0, ce}, 32'd1);
        RESET = 1'b0;
        #1;
        chk("async_ce", {31'd0, ce}, 32'd0);
        chk("async_resetn", {31'd0, resetn}, 32'd0);
        chk("async_count", ce_count, 32'd0);
        tick(2);
        RESET = 1'b1;
        tick(HOLD + 4);

        // Randomised traffic
        rl = 1;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 59) == 0) begin
                mode = 2'($urandom_range(0, 3));
                div  = DW'($urandom_range(0, 7));
            end
            rl--;
            if (rl <= 0) begin
                step_btn = ~step_btn;
                rl = $urandom_range(1, 12);
            end
            soft_reset = ($urandom_range(0, 249) == 0);
            tick(1);
        end
        soft_reset = 1'b0;
        tick(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/clock_sequencer.md
# clock_sequencer

Parametrised clock-enable and reset sequencer for the tutorial SoCs.
- Runs the whole design on the board clock and produces a single clock-enable `ce` with four modes: free run, programmable divide, single-step from a debounced button, and pause.
- Produces a timed, synchronously deasserted `resetn` that covers the BRAM power-up garbage window and can be re-armed from software.
- Sits between the board pins and the CPU/SoC top. All design registers use `CLK` and qualify updates with `ce`.

## Interface
- `HOLD_CYCLES`, default 4096: cycles `resetn` is held low after reset release or a soft reset. Legal range is 1 to 65535.
- `DIV_W`, default 24: width of the divide-ratio input.
- `DEB_CYCLES`, default 65536: consecutive stable cycles required before the step button changes state.
- `CLK` input, 1 bit: board clock, used for every register.
- `RESET` input, 1 bit: asynchronous, active-low reset. CLK is the clock.
- `mode` input, 2 bits:
  - 00: RUN
  - 01: DIV
  - 10: STEP
  - 11: PAUSE
  - Treated as quasi-static.
- `div` input, DIV_W bits: in DIV mode, `ce` period is `div+1` cycles.
- `step_btn` input, 1 bit: raw, asynchronous, active-high push button.
- `soft_reset` input, 1 bit: synchronous one-cycle request to re-run the hold sequence.
- `resetn` output, 1 bit: registered, active-low reset for the design.
- `ce` output, 1 bit: registered clock enable.
- `ce_count` output, 32 bits: number of cycles in which `ce` was 1. It wraps.

## Operation
- **Reset synchroniser.**
  - `RESET` low asynchronously clears two flops, `rs1` and `rs2`.
  - When `RESET` is high, `rs1` loads 1 and `rs2` loads `rs1`.
  - `rs2` is the internal run permission.
- **Hold FSM states: HOLD and RUN.**
  - `RESET` low forces HOLD: `hold_cnt` = 0, `resetn` = 0, `ce` = 0, `ce_count` = 0, divider count = 0, and the debounce state is cleared.
  - HOLD: while `rs2` = 1, `hold_cnt` increments.
  - When `hold_cnt` equals `HOLD_CYCLES-1`, the FSM moves to RUN and `resetn` is registered to 1.
  - `rs2` = 0 keeps `hold_cnt` at 0.
  - RUN: `soft_reset` = 1 returns the FSM to HOLD with `hold_cnt` = 0. On the next edge `resetn` = 0, `ce` = 0, `ce_count` = 0 and divider count = 0.
  - `soft_reset` is ignored while already in HOLD; it does not restart the count.
- **`ce` generation in RUN.** `ce` is always 0 in HOLD.
  - RUN mode: `ce` is 1 every cycle.
  - DIV mode:
    - If `dcnt >= div`, then `ce` is 1 and `dcnt` is reset to 0.
    - Otherwise `ce` is 0 and `dcnt` increments.
    - `div` = 0 gives `ce` = 1 every cycle.
    - Using `>=` means lowering `div` below the current `dcnt` never stalls; the next cycle pulses.
  - STEP mode: each rising edge of the debounced button gives exactly one `ce` = 1 cycle. Holding the button does not repeat.
  - PAUSE mode: `ce` is 0.
  - Any change of `mode` clears `dcnt` to 0 in the cycle after the change.
- **Debouncer.**
  - `step_btn` passes through a 2-flop synchroniser to give `bs`.
  - `deb_cnt` counts while `bs` differs from `deb` and clears when they are equal.
  - At `DEB_CYCLES-1`, `deb` takes the value of `bs` and `deb_cnt` clears.
  - The edge detector compares `deb` with `deb_q`. It runs in all modes, so a press made outside STEP, or during HOLD, is consumed and never fires later.
- **`ce_count`.** Increments by 1 on every cycle where registered `ce` = 1. It wraps from 0xFFFFFFFF to 0 and is cleared by hardware or soft reset.

## Timing
- Reset values: `resetn` = 0, `ce` = 0, `ce_count` = 0.
- Let edge E0 be the first `CLK` rising edge after `RESET` rises, with setup met.
  - `rs2` = 1 after E1.
  - `resetn` = 1 after edge E(1+HOLD_CYCLES).
- After a soft reset, `resetn` = 1 again `HOLD_CYCLES`+1 edges after the edge that sampled `soft_reset`.
- RUN mode: `ce` = 1 starting one cycle after `resetn` rises.
- DIV mode: the first `ce` pulse comes `div+1` cycles after `resetn` rises, then repeats every `div+1` cycles.
- STEP mode: `ce` pulses 2 (sync) + `DEB_CYCLES` + 1 cycles after a clean press.
- `RESET` low at any time, including mid-pulse, clears all outputs immediately and asynchronously.

## Test plan
- Power-up with `HOLD_CYCLES`=8, `mode`=RUN: release `RESET` -> `resetn` rises at E9 and `ce` = 1 from the next cycle. Check `ce_count` = 10 after 10 further cycles.
- DIV with `div`=3: check `ce` pattern 0001 repeating. Change `div` to 0 while `dcnt` = 2 -> `ce` = 1 every cycle, with no stall.
- STEP with `DEB_CYCLES`=4:
  - Bounce of 3 cycles, then a 20-cycle clean press -> exactly one `ce` pulse.
  - A second press -> `ce_count` = 2.
- `soft_reset` pulse in RUN -> `resetn` = 0 and `ce_count` = 0 next cycle; `resetn` returns to 1 after `HOLD_CYCLES`+1 edges. A `soft_reset` during HOLD does not extend the hold.
- `RESET` asserted mid-DIV-pulse -> `ce` and `resetn` drop asynchronously with no clock edge.
- PAUSE, then press the step button, then switch to STEP -> no `ce` pulse. Mode change RUN to DIV (`div`=2) -> first pulse 3 cycles after the change.
